// File: rtl/sram_d_obi_arbiter.sv
// ---------------------------------------------------------------------------
// sram_d_obi_arbiter: round-robin 2:1 OBI arbiter for the SRAM data port,
// with address-window check, local error responses and in-order routing.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sram_d_obi_arbiter #(
  parameter logic [31:0] SRAM_BASE_ADDR  = 32'h8000_0000,
  parameter logic [31:0] SRAM_END_ADDR   = 32'h8000_C000,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter logic [31:0] ERR_RDATA       = 32'hBADC_0FFE
) (
  input  logic        clk_i,
  input  logic        rst_ni,

  input  logic        m0_req_i,
  output logic        m0_gnt_o,
  input  logic [31:0] m0_addr_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_be_i,
  input  logic [31:0] m0_wdata_i,
  output logic        m0_rvalid_o,
  output logic [31:0] m0_rdata_o,
  output logic        m0_err_o,

  input  logic        m1_req_i,
  output logic        m1_gnt_o,
  input  logic [31:0] m1_addr_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_be_i,
  input  logic [31:0] m1_wdata_i,
  output logic        m1_rvalid_o,
  output logic [31:0] m1_rdata_o,
  output logic        m1_err_o,

  output logic        sram_d_req_o,
  input  logic        sram_d_gnt_i,
  output logic [31:0] sram_d_addr_o,
  output logic        sram_d_we_o,
  output logic [3:0]  sram_d_be_o,
  output logic [31:0] sram_d_wdata_o,
  input  logic        sram_d_rvalid_i,
  input  logic [31:0] sram_d_rdata_i,

  output logic        illegal_access_o
);

  localparam int unsigned c_IDX_W = $clog2(MAX_OUTSTANDING);
  localparam int unsigned c_PTR_W = c_IDX_W + 1;

  logic                       rr_q;
  logic [c_PTR_W-1:0]         wptr_q, wptr_d;
  logic [c_PTR_W-1:0]         rptr_q, rptr_d;
  logic [MAX_OUTSTANDING-1:0] id_q;
  logic [MAX_OUTSTANDING-1:0] ill_q;
  logic                       err_resp_q, err_resp_d;

  logic        w_any_req;
  logic        w_win;
  logic [31:0] w_addr;
  logic        w_we;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic        w_legal;
  logic        w_empty;
  logic        w_full;
  logic        w_head_id;
  logic        w_head_ill;
  logic        w_pop_legal;
  logic        w_pop;
  logic        w_block;
  logic        w_gnt;
  logic        w_nxt_ill;
  logic [31:0] w_rsp_data;

  // Gating with rst_ni keeps every output low for the whole reset window.
  always_comb begin
    w_any_req = rst_ni && (m0_req_i || m1_req_i);
    if (m0_req_i && m1_req_i) begin
      w_win = rr_q;
    end else begin
      w_win = m1_req_i;
    end
  end

  assign w_addr  = w_win ? m1_addr_i  : m0_addr_i;
  assign w_we    = w_win ? m1_we_i    : m0_we_i;
  assign w_be    = w_win ? m1_be_i    : m0_be_i;
  assign w_wdata = w_win ? m1_wdata_i : m0_wdata_i;
  assign w_legal = (w_addr >= SRAM_BASE_ADDR) && (w_addr < SRAM_END_ADDR);

  assign w_empty    = (wptr_q == rptr_q);
  assign w_full     = (wptr_q[c_IDX_W] != rptr_q[c_IDX_W]) &&
                      (wptr_q[c_IDX_W-1:0] == rptr_q[c_IDX_W-1:0]);
  assign w_head_id  = id_q[rptr_q[c_IDX_W-1:0]];
  assign w_head_ill = ill_q[rptr_q[c_IDX_W-1:0]];

  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign w_pop_legal = sram_d_rvalid_i && !w_empty && !w_head_ill;
  assign w_pop       = w_pop_legal || err_resp_q;
  assign w_block     = w_full && !w_pop;
  assign w_gnt       = w_any_req && !w_block && (w_legal ? sram_d_gnt_i : 1'b1);

  assign sram_d_req_o     = w_any_req && w_legal && !w_block;
  assign sram_d_addr_o    = sram_d_req_o ? w_addr  : '0;
  assign sram_d_we_o      = sram_d_req_o && w_we;
  assign sram_d_be_o      = sram_d_req_o ? w_be    : '0;
  assign sram_d_wdata_o   = sram_d_req_o ? w_wdata : '0;
  assign m0_gnt_o         = w_gnt && !w_win;
  assign m1_gnt_o         = w_gnt &&  w_win;
  assign illegal_access_o = w_gnt && !w_legal;

  assign wptr_d = wptr_q + c_PTR_W'(w_gnt);
  assign rptr_d = rptr_q + c_PTR_W'(w_pop);

  // err_resp_q tracks "next cycle's head is an illegal entry", so an illegal
  // access answers in the cycle after it becomes (or is pushed as) the head.
  always_comb begin
    if (w_gnt && (rptr_d == wptr_q)) begin
      w_nxt_ill = !w_legal;
    end else begin
      w_nxt_ill = ill_q[rptr_d[c_IDX_W-1:0]];
    end
    err_resp_d = (wptr_d != rptr_d) && w_nxt_ill;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q       <= 1'b0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      id_q       <= '0;
      ill_q      <= '0;
      err_resp_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      err_resp_q <= err_resp_d;
      if (w_gnt) begin
        rr_q                          <= !w_win;
        id_q[wptr_q[c_IDX_W-1:0]]  <= w_win;
        ill_q[wptr_q[c_IDX_W-1:0]] <= !w_legal;
      end
    end
  end

  assign w_rsp_data  = err_resp_q ? ERR_RDATA : sram_d_rdata_i;
  assign m0_rvalid_o = w_pop && !w_head_id;
  assign m1_rvalid_o = w_pop &&  w_head_id;
  assign m0_rdata_o  = m0_rvalid_o ? w_rsp_data : '0;
  assign m1_rdata_o  = m1_rvalid_o ? w_rsp_data : '0;
  assign m0_err_o    = m0_rvalid_o && err_resp_q;
  assign m1_err_o    = m1_rvalid_o && err_resp_q;

  a_no_push_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
    w_gnt |-> (!w_full || w_pop));
  a_no_pop_empty: assert property (@(posedge clk_i) disable iff (!rst_ni)
    w_pop |-> !w_empty);
  a_rvalid_nonempty: assert property (@(posedge clk_i) disable iff (!rst_ni)
    sram_d_rvalid_i |-> !w_empty);
  a_rvalid_on_illegal: assert property (@(posedge clk_i) disable iff (!rst_ni)
    sram_d_rvalid_i |-> !w_head_ill);

endmodule

`default_nettype wire

// File: tb/tb_sram_d_obi_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sram_d_obi_arbiter: directed scenarios plus a randomized run against a
// queue-based reference model of the arbiter. Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_sram_d_obi_arbiter;

  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam logic [31:0] END_A = 32'h8000_C000;
  localparam logic [31:0] ERRD  = 32'hBADC_0FFE;
  localparam int          MAXO  = 2;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  logic m0_req_i, m0_gnt_o, m0_we_i, m0_rvalid_o, m0_err_o;
  logic m1_req_i, m1_gnt_o, m1_we_i, m1_rvalid_o, m1_err_o;
  logic [31:0] m0_addr_i, m0_wdata_i, m0_rdata_o, m1_addr_i, m1_wdata_i, m1_rdata_o;
  logic [3:0]  m0_be_i, m1_be_i, sram_d_be_o;
  logic sram_d_req_o, sram_d_gnt_i, sram_d_we_o, sram_d_rvalid_i, illegal_access_o;
  logic [31:0] sram_d_addr_o, sram_d_wdata_o, sram_d_rdata_i;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  typedef struct { logic [31:0] addr; logic we; logic [3:0] be; logic [31:0] wdata; } txn_t;
  typedef struct { int m; logic [31:0] data; bit err; int ready; } exp_t;
  typedef struct { logic [31:0] data; int ready; } slv_t;

  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] slv_mem [logic [31:0]];

  sram_d_obi_arbiter #(
    .SRAM_BASE_ADDR(BASE), .SRAM_END_ADDR(END_A),
    .MAX_OUTSTANDING(MAXO), .ERR_RDATA(ERRD)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .m0_req_i(m0_req_i), .m0_gnt_o(m0_gnt_o), .m0_addr_i(m0_addr_i), .m0_we_i(m0_we_i),
    .m0_be_i(m0_be_i), .m0_wdata_i(m0_wdata_i), .m0_rvalid_o(m0_rvalid_o),
    .m0_rdata_o(m0_rdata_o), .m0_err_o(m0_err_o),
    .m1_req_i(m1_req_i), .m1_gnt_o(m1_gnt_o), .m1_addr_i(m1_addr_i), .m1_we_i(m1_we_i),
    .m1_be_i(m1_be_i), .m1_wdata_i(m1_wdata_i), .m1_rvalid_o(m1_rvalid_o),
    .m1_rdata_o(m1_rdata_o), .m1_err_o(m1_err_o),
    .sram_d_req_o(sram_d_req_o), .sram_d_gnt_i(sram_d_gnt_i), .sram_d_addr_o(sram_d_addr_o),
    .sram_d_we_o(sram_d_we_o), .sram_d_be_o(sram_d_be_o), .sram_d_wdata_o(sram_d_wdata_o),
    .sram_d_rvalid_i(sram_d_rvalid_i), .sram_d_rdata_i(sram_d_rdata_i),
    .illegal_access_o(illegal_access_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [31:0] be_merge(input logic [31:0] o, input logic [31:0] n,
                                           input logic [3:0] be);
    for (int b = 0; b < 4; b++) if (be[b]) o[8*b +: 8] = n[8*b +: 8];
    return o;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : (a ^ 32'hC3C3_3C3C);
  endfunction

  function automatic logic [31:0] slv_rd(input logic [31:0] a);
    return slv_mem.exists(a) ? slv_mem[a] : (a ^ 32'hC3C3_3C3C);
  endfunction

  function automatic logic [31:0] pick_addr();
    case ($urandom_range(0, 7))
      0:       return BASE;
      1:       return END_A - 32'd4;
      2:       return END_A;
      3:       return BASE - 32'd4;
      4:       return $urandom;
      default: return BASE + 32'($urandom_range(0, 15)) * 32'd4;
    endcase
  endfunction

  task automatic idle_inputs();
    m0_req_i = 0; m0_addr_i = 0; m0_we_i = 0; m0_be_i = 0; m0_wdata_i = 0;
    m1_req_i = 0; m1_addr_i = 0; m1_we_i = 0; m1_be_i = 0; m1_wdata_i = 0;
    sram_d_gnt_i = 0; sram_d_rvalid_i = 0; sram_d_rdata_i = 0;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
    cyc++;
  endtask

  task automatic reset_pulse();
    idle_inputs();
    rst_ni = 0;
    tick();
    tick();
    rst_ni = 1;
  endtask

  task automatic test_reset();
    idle_inputs();
    m0_req_i = 1; m0_addr_i = BASE; m1_req_i = 1; m1_addr_i = END_A; sram_d_gnt_i = 1;
    rst_ni = 0;
    tick();
    @(negedge clk_i);
    n_chk++;
    if ({m0_gnt_o, m1_gnt_o, sram_d_req_o, illegal_access_o, m0_rvalid_o, m1_rvalid_o,
         m0_err_o, m1_err_o} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b expected 00000000", {m0_gnt_o, m1_gnt_o, sram_d_req_o,
               illegal_access_o, m0_rvalid_o, m1_rvalid_o, m0_err_o, m1_err_o});
    end
    n_chk++;
    if ((m0_rdata_o !== 32'h0) || (m1_rdata_o !== 32'h0)) begin
      n_fail++;
      $display("FAIL reset_rdata: got %h/%h expected 0/0", m0_rdata_o, m1_rdata_o);
    end
    tick();
    idle_inputs();
    rst_ni = 1;
    tick();
  endtask

  task automatic test_single_read();
    m0_req_i = 1; m0_addr_i = 32'h8000_0010; m0_we_i = 0; m0_be_i = 4'hF; sram_d_gnt_i = 1;
    @(negedge clk_i);
    n_chk++;
    if ({m0_gnt_o, m1_gnt_o, sram_d_req_o} !== 3'b101 || sram_d_addr_o !== 32'h8000_0010) begin
      n_fail++;
      $display("FAIL read_grant: got gnt=%b%b req=%b addr=%h expected 1 0 1 80000010",
               m0_gnt_o, m1_gnt_o, sram_d_req_o, sram_d_addr_o);
    end
    tick();
    m0_req_i = 0; sram_d_rvalid_i = 1; sram_d_rdata_i = 32'h1234_5678;
    @(negedge clk_i);
    n_chk++;
    if ({m0_rvalid_o, m0_err_o, m1_rvalid_o} !== 3'b100 || m0_rdata_o !== 32'h1234_5678) begin
      n_fail++;
      $display("FAIL read_resp: got rv=%b err=%b m1rv=%b data=%h expected 1 0 0 12345678",
               m0_rvalid_o, m0_err_o, m1_rvalid_o, m0_rdata_o);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_illegal();
    m1_req_i = 1; m1_addr_i = END_A; m1_we_i = 1; m1_be_i = 4'hF; m1_wdata_i = 32'h5555_AAAA;
    sram_d_gnt_i = 1;
    @(negedge clk_i);
    n_chk++;
    if ({sram_d_req_o, m1_gnt_o, m0_gnt_o, illegal_access_o} !== 4'b0101) begin
      n_fail++;
      $display("FAIL illegal_grant: got req=%b gnt1=%b gnt0=%b ill=%b expected 0 1 0 1",
               sram_d_req_o, m1_gnt_o, m0_gnt_o, illegal_access_o);
    end
    tick();
    m1_req_i = 0;
    @(negedge clk_i);
    n_chk++;
    if ({m1_rvalid_o, m1_err_o, m0_rvalid_o, illegal_access_o} !== 4'b1100 || m1_rdata_o !== ERRD) begin
      n_fail++;
      $display("FAIL illegal_resp: got rv=%b err=%b m0rv=%b ill=%b data=%h expected 1 1 0 0 %h",
               m1_rvalid_o, m1_err_o, m0_rvalid_o, illegal_access_o, m1_rdata_o, ERRD);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_gnt_stall();
    m0_req_i = 1; m0_addr_i = 32'h8000_0100; m0_be_i = 4'hF; sram_d_gnt_i = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      n_chk++;
      if (m0_gnt_o !== 1'b0 || sram_d_req_o !== 1'b1 || sram_d_addr_o !== 32'h8000_0100) begin
        n_fail++;
        $display("FAIL stall_hold: got gnt=%b req=%b addr=%h expected 0 1 80000100",
                 m0_gnt_o, sram_d_req_o, sram_d_addr_o);
      end
      tick();
    end
    sram_d_gnt_i = 1;
    @(negedge clk_i);
    n_chk++;
    if (m0_gnt_o !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_release: got gnt=%b expected 1", m0_gnt_o);
    end
    tick();
    m0_req_i = 0; sram_d_gnt_i = 0; sram_d_rvalid_i = 1; sram_d_rdata_i = 32'hCAFE_0001;
    @(negedge clk_i);
    n_chk++;
    if (m0_rvalid_o !== 1'b1 || m0_rdata_o !== 32'hCAFE_0001) begin
      n_fail++;
      $display("FAIL stall_resp: got rv=%b data=%h expected 1 cafe0001", m0_rvalid_o, m0_rdata_o);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_fifo_full();
    logic [31:0] exp_gnt_seq;
    logic [31:0] exp_req_seq;
    exp_gnt_seq = 32'b0_1_0_1_1;   // LSB first: grant, grant, blocked, pop+push, blocked
    exp_req_seq = 32'b0_1_0_1_1;
    m0_req_i = 1; m0_be_i = 4'hF; sram_d_gnt_i = 1;
    for (int i = 0; i < 5; i++) begin
      m0_addr_i = 32'h8000_0200 + 32'(i) * 32'd4;
      sram_d_rvalid_i = (i == 3);
      sram_d_rdata_i  = 32'hD000_0001;
      @(negedge clk_i);
      n_chk++;
      if (m0_gnt_o !== exp_gnt_seq[i] || sram_d_req_o !== exp_req_seq[i]) begin
        n_fail++;
        $display("FAIL full_gnt[%0d]: got gnt=%b req=%b expected %b %b", i, m0_gnt_o,
                 sram_d_req_o, exp_gnt_seq[i], exp_req_seq[i]);
      end
      if (i == 3) begin
        n_chk++;
        if (m0_rvalid_o !== 1'b1 || m0_rdata_o !== 32'hD000_0001) begin
          n_fail++;
          $display("FAIL full_pop: got rv=%b data=%h expected 1 d0000001", m0_rvalid_o, m0_rdata_o);
        end
      end
      if (exp_gnt_seq[i] && i < 3) ; else if (i == 3) m0_addr_i = m0_addr_i;
      tick();
    end
    m0_req_i = 0;
    for (int i = 0; i < 2; i++) begin
      sram_d_rvalid_i = 1; sram_d_rdata_i = 32'hD000_0002 + 32'(i);
      @(negedge clk_i);
      n_chk++;
      if (m0_rvalid_o !== 1'b1 || m0_rdata_o !== 32'hD000_0002 + 32'(i)) begin
        n_fail++;
        $display("FAIL full_drain[%0d]: got rv=%b data=%h expected 1 %h", i, m0_rvalid_o,
                 m0_rdata_o, 32'hD000_0002 + 32'(i));
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_interleave();
    m0_req_i = 1; m0_addr_i = 32'h8000_0300; m0_be_i = 4'hF; sram_d_gnt_i = 1;
    @(negedge clk_i);
    n_chk++;
    if (m0_gnt_o !== 1'b1) begin
      n_fail++;
      $display("FAIL inter_g0: got %b expected 1", m0_gnt_o);
    end
    tick();
    m0_req_i = 0; m1_req_i = 1; m1_addr_i = BASE - 32'd4;
    @(negedge clk_i);
    n_chk++;
    if ({m1_gnt_o, illegal_access_o, sram_d_req_o} !== 3'b110) begin
      n_fail++;
      $display("FAIL inter_g1: got gnt=%b ill=%b req=%b expected 1 1 0", m1_gnt_o,
               illegal_access_o, sram_d_req_o);
    end
    tick();
    m1_req_i = 0;
    @(negedge clk_i);
    n_chk++;
    if ({m0_rvalid_o, m1_rvalid_o} !== 2'b00) begin
      n_fail++;
      $display("FAIL inter_wait: got rv=%b%b expected 00", m0_rvalid_o, m1_rvalid_o);
    end
    tick();
    sram_d_rvalid_i = 1; sram_d_rdata_i = 32'h0303_0303;
    @(negedge clk_i);
    n_chk++;
    if ({m0_rvalid_o, m1_rvalid_o} !== 2'b10 || m0_rdata_o !== 32'h0303_0303) begin
      n_fail++;
      $display("FAIL inter_r0: got rv=%b%b data=%h expected 10 03030303", m0_rvalid_o,
               m1_rvalid_o, m0_rdata_o);
    end
    tick();
    sram_d_rvalid_i = 0;
    @(negedge clk_i);
    n_chk++;
    if ({m0_rvalid_o, m1_rvalid_o, m1_err_o} !== 3'b011 || m1_rdata_o !== ERRD) begin
      n_fail++;
      $display("FAIL inter_r1: got rv=%b%b err=%b data=%h expected 01 1 %h", m0_rvalid_o,
               m1_rvalid_o, m1_err_o, m1_rdata_o, ERRD);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    m0_req_i = 1; m0_addr_i = 32'h8000_0400; m0_be_i = 4'hF; sram_d_gnt_i = 1;
    @(negedge clk_i);
    n_chk++;
    if (m0_gnt_o !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_g: got %b expected 1", m0_gnt_o);
    end
    tick();
    m1_req_i = 1; m1_addr_i = 32'h8000_0500; m1_be_i = 4'hF;
    rst_ni = 0;
    #1;
    n_chk++;
    if ({m0_gnt_o, m1_gnt_o, sram_d_req_o, m0_rvalid_o, m1_rvalid_o, illegal_access_o} !== 6'b0) begin
      n_fail++;
      $display("FAIL rstmid_async: got %b expected 000000", {m0_gnt_o, m1_gnt_o, sram_d_req_o,
               m0_rvalid_o, m1_rvalid_o, illegal_access_o});
    end
    tick();
    rst_ni = 1;
    @(negedge clk_i);
    n_chk++;
    if ({m0_gnt_o, m1_gnt_o} !== 2'b10) begin
      n_fail++;
      $display("FAIL rstmid_first: got %b%b expected 10", m0_gnt_o, m1_gnt_o);
    end
    tick();
    m0_req_i = 0; m1_req_i = 0; sram_d_rvalid_i = 1; sram_d_rdata_i = 32'h0404_0404;
    @(negedge clk_i);
    n_chk++;
    if ({m0_rvalid_o, m1_rvalid_o} !== 2'b10 || m0_rdata_o !== 32'h0404_0404) begin
      n_fail++;
      $display("FAIL rstmid_resp: got rv=%b%b data=%h expected 10 04040404", m0_rvalid_o,
               m1_rvalid_o, m0_rdata_o);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_round_robin();
    reset_pulse();
    m0_req_i = 1; m0_addr_i = BASE + 32'h20; m0_be_i = 4'hF;
    m1_req_i = 1; m1_addr_i = BASE + 32'h40; m1_be_i = 4'hF;
    sram_d_gnt_i = 1;
    for (int k = 0; k < 9; k++) begin
      if (k == 8) begin m0_req_i = 0; m1_req_i = 0; end
      sram_d_rvalid_i = (k >= 1);
      sram_d_rdata_i  = 32'hA000_0000 + 32'(k);
      @(negedge clk_i);
      if (k < 8) begin
        n_chk++;
        if (m0_gnt_o !== (k % 2 == 0) || m1_gnt_o !== (k % 2 == 1)) begin
          n_fail++;
          $display("FAIL rr_gnt[%0d]: got %b%b expected m%0d", k, m0_gnt_o, m1_gnt_o, k % 2);
        end
      end
      if (k >= 1) begin
        n_chk++;
        if (((k - 1) % 2 == 0) ? (m0_rvalid_o !== 1'b1 || m1_rvalid_o !== 1'b0 ||
                                  m0_rdata_o !== 32'hA000_0000 + 32'(k))
                               : (m1_rvalid_o !== 1'b1 || m0_rvalid_o !== 1'b0 ||
                                  m1_rdata_o !== 32'hA000_0000 + 32'(k))) begin
          n_fail++;
          $display("FAIL rr_resp[%0d]: got rv=%b%b data=%h/%h expected m%0d %h", k, m0_rvalid_o,
                   m1_rvalid_o, m0_rdata_o, m1_rdata_o, (k - 1) % 2, 32'hA000_0000 + 32'(k));
        end
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_random(input int ncyc);
    txn_t cur[2];
    bit   busy[2];
    exp_t eq[$];
    slv_t sq[$];
    exp_t e;
    int   rr, win;
    bit   any, legal, blocked, exp_pop, exp_gnt, exp_sreq, was_empty, head_legal;
    logic [31:0] a, d;
    reset_pulse();
    ref_mem.delete();
    slv_mem.delete();
    rr = 0; busy[0] = 0; busy[1] = 0;
    for (int c = 0; c < ncyc + 40; c++) begin
      for (int m = 0; m < 2; m++) begin
        if (!busy[m] && c < ncyc && $urandom_range(0, 3) != 0) begin
          cur[m].addr = pick_addr(); cur[m].we = 1'($urandom_range(0, 1));
          cur[m].be = 4'($urandom_range(1, 15)); cur[m].wdata = $urandom; busy[m] = 1;
        end
      end
      m0_req_i = busy[0]; m0_addr_i = cur[0].addr; m0_we_i = cur[0].we;
      m0_be_i = cur[0].be; m0_wdata_i = cur[0].wdata;
      m1_req_i = busy[1]; m1_addr_i = cur[1].addr; m1_we_i = cur[1].we;
      m1_be_i = cur[1].be; m1_wdata_i = cur[1].wdata;
      sram_d_gnt_i = ($urandom_range(0, 3) != 0);
      head_legal = (eq.size() > 0) && !eq[0].err;
      if (sq.size() > 0 && sq[0].ready <= cyc && head_legal) begin
        sram_d_rvalid_i = 1; sram_d_rdata_i = sq[0].data;
      end else begin
        sram_d_rvalid_i = 0; sram_d_rdata_i = $urandom;
      end
      exp_pop = 0;
      if (eq.size() > 0) exp_pop = eq[0].err ? (cyc >= eq[0].ready) : sram_d_rvalid_i;
      win      = (busy[0] && busy[1]) ? rr : (busy[1] ? 1 : 0);
      any      = busy[0] || busy[1];
      legal    = (cur[win].addr >= BASE) && (cur[win].addr < END_A);
      blocked  = (eq.size() >= MAXO) && !exp_pop;
      exp_gnt  = any && !blocked && (legal ? sram_d_gnt_i : 1'b1);
      exp_sreq = any && legal && !blocked;
      @(negedge clk_i);
      n_chk++;
      if ({m0_gnt_o, m1_gnt_o, sram_d_req_o, illegal_access_o} !==
          {exp_gnt && win == 0, exp_gnt && win == 1, exp_sreq, exp_gnt && !legal}) begin
        n_fail++;
        $display("FAIL rand_ctrl@%0d: got %b expected %b", cyc,
                 {m0_gnt_o, m1_gnt_o, sram_d_req_o, illegal_access_o},
                 {exp_gnt && win == 0, exp_gnt && win == 1, exp_sreq, exp_gnt && !legal});
      end
      if (exp_sreq) begin
        n_chk++;
        if ({sram_d_addr_o, sram_d_we_o, sram_d_be_o, sram_d_wdata_o} !==
            {cur[win].addr, cur[win].we, cur[win].be, cur[win].wdata}) begin
          n_fail++;
          $display("FAIL rand_mux@%0d: got %h %b %h %h expected %h %b %h %h", cyc, sram_d_addr_o,
                   sram_d_we_o, sram_d_be_o, sram_d_wdata_o, cur[win].addr, cur[win].we,
                   cur[win].be, cur[win].wdata);
        end
      end
      n_chk++;
      if ({m0_rvalid_o, m1_rvalid_o} !== {exp_pop && eq[0].m == 0, exp_pop && eq[0].m == 1}) begin
        n_fail++;
        $display("FAIL rand_rvalid@%0d: got %b%b expected %b%b", cyc, m0_rvalid_o, m1_rvalid_o,
                 exp_pop && eq[0].m == 0, exp_pop && eq[0].m == 1);
      end
      if (exp_pop) begin
        n_chk++;
        if ((eq[0].m == 0) ? ({m0_rdata_o, m0_err_o} !== {eq[0].data, eq[0].err})
                           : ({m1_rdata_o, m1_err_o} !== {eq[0].data, eq[0].err})) begin
          n_fail++;
          $display("FAIL rand_rdata@%0d: got %h/%b %h/%b expected m%0d %h/%b", cyc, m0_rdata_o,
                   m0_err_o, m1_rdata_o, m1_err_o, eq[0].m, eq[0].data, eq[0].err);
        end
      end
      if (sram_d_req_o && sram_d_gnt_i) begin
        a = sram_d_addr_o;
        if (sram_d_we_o) begin
          slv_mem[a] = be_merge(slv_rd(a), sram_d_wdata_o, sram_d_be_o);
          d = 32'h0;
        end else begin
          d = slv_rd(a);
        end
        sq.push_back('{data: d, ready: cyc + 1 + $urandom_range(0, 2)});
      end
      if (sram_d_rvalid_i && sq.size() > 0) void'(sq.pop_front());
      was_empty = (eq.size() == 0);
      if (exp_pop) void'(eq.pop_front());
      if (exp_gnt) begin
        a = cur[win].addr;
        e.m = win; e.err = !legal; e.ready = 0;
        if (!legal) begin
          e.data = ERRD;
        end else if (cur[win].we) begin
          ref_mem[a] = be_merge(ref_rd(a), cur[win].wdata, cur[win].be);
          e.data = 32'h0;
        end else begin
          e.data = ref_rd(a);
        end
        eq.push_back(e);
        rr = 1 - win;
        busy[win] = 0;
      end
      if ((exp_pop || was_empty) && eq.size() > 0) eq[0].ready = cyc + 1;
      tick();
    end
    n_chk++;
    if (eq.size() != 0 || busy[0] || busy[1]) begin
      n_fail++;
      $display("FAIL rand_drain: got %0d pending, busy %b%b expected 0 pending", eq.size(),
               busy[0], busy[1]);
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single_read();
    test_illegal();
    test_gnt_stall();
    test_fifo_full();
    test_interleave();
    test_reset_mid();
    test_round_robin();
    test_random(500);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
